stepper_clock_gen: RTL and testbench
====================================

Name: stepper_clock_gen

Overview:
Parametrised successor to clock_gen for the 7 Step Processor. It derives the four computer-clock phase signals clk, clk_d, clk_e and clk_s from sys_clk as registered, glitch-free levels. It also owns the instruction stepper and adds run, single-step and halt-at-instruction-end control. It sits between the board clock and the control unit, replacing the separate clock_gen and stepper blocks.

Parameters:
QTR_CYCLES, 1, sys_clk cycles per quarter phase; must be >= 1; one computer cycle = 4*QTR_CYCLES sys_clk.
STEPS, 7, stepper length including the final stepper-reset step; must be >= 2.

Ports:
sys_clk  in  1  system clock, single clock domain; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
run  in  1  free-run enable; only used when single=0
single  in  1  single-step mode select
step_req  in  1  1-sys_clk pulse that requests exactly one computer cycle; also clears halted
halt  in  1  level; stop at the end of the current instruction
clk  out  1  computer clock
clk_d  out  1  clk delayed by one quarter phase
clk_e  out  1  enable phase, equal to clk | clk_d
clk_s  out  1  set phase, equal to clk & clk_d
step  out  STEPS  one-hot stepper; step[STEPS-1] is the stepper-reset step
cycle_end  out  1  high during the last sys_clk of phase 3
instr_end  out  1  cycle_end & step[STEPS-1]
halted  out  1  block is idle because halt was honoured

Behaviour:
- Clock and reset: one clock (sys_clk). Reset is synchronous and active-high (reset).
- Reset values: state IDLE, phase 0, quarter counter 0, step = 1 (step[0]), halted 0. clk, clk_d, clk_e, clk_s, cycle_end and instr_end are all 0.
- Internal state: FSM {IDLE, RUN}, 2-bit phase, quarter counter of width clog2(QTR_CYCLES) (minimum 1 bit), step index.
- Phase decode, valid only in RUN:
  - phase 0: clk=1, clk_d=0
  - phase 1: clk=1, clk_d=1
  - phase 2: clk=0, clk_d=1
  - phase 3: clk=0, clk_d=0
  - Resulting per-phase values: clk_e = 1,1,1,0 and clk_s = 0,1,0,0.
- In IDLE, all four phase outputs are 0.
- Phase outputs are decoded from registered state only. No combinational path runs from any input to any output.
- Quarter counter: counts 0..QTR_CYCLES-1, then wraps to 0 and advances the phase. Phase 3 wraps to phase 0.
- At the end of phase 3 (the cycle_end sys_clk): the step index advances, and step[STEPS-1] wraps to step[0].
- Step changes only at cycle boundaries and never in IDLE.
- IDLE -> RUN: taken when (single=0 & run=1 & halted=0) or (single=1 & step_req=1).
  - Sampled on an edge; phase 0 outputs are visible from the next sys_clk.
  - step_req=1 in IDLE also clears halted. In free-run, step_req acts as a restart.
- RUN, at each cycle_end, in priority order:
  1. If instr_end and halt=1: go to IDLE and set halted=1.
  2. Else if single=1: go to IDLE; halted stays 0.
  3. Else if run=0: go to IDLE.
  4. Else: stay in RUN at phase 0. There is no idle gap between back-to-back cycles.
- A computer cycle is never truncated. run, single and halt changes take effect only at cycle_end.
- step_req received while in RUN is ignored and not queued.
- halt is sampled only at instr_end. A halt pulse that ends before instr_end has no effect.
- While halted=1 and single=0, run=1 does not restart the block. Only step_req or reset restarts it.
- reset mid-cycle: on the next edge all state returns to reset values, regardless of phase or step.
- cycle_end and instr_end are 1-sys_clk pulses, asserted only in RUN.

Test Plan:
1. QTR_CYCLES=1, STEPS=7, release reset with run=1, single=0 -> clk 1,1,0,0; clk_d 0,1,1,0; clk_e 1,1,1,0; clk_s 0,1,0,0 repeating. step walks 0x01..0x40 and back to 0x01 every 4 sys_clk. instr_end pulses every 28 sys_clk.
2. QTR_CYCLES=3, run=1 -> each phase lasts 3 sys_clk. cycle_end pulses every 12 sys_clk, in the 3rd sys_clk of phase 3.
3. single=1, one step_req pulse from IDLE at step=0x04 -> exactly 4 phases, then IDLE with step=0x08 and outputs 0. A second step_req issued mid-cycle is ignored: step stays 0x08 and the block stays idle.
4. run=1, halt raised during step 0x04 -> the cycles at step 0x08 through 0x40 still run. After that instr_end: IDLE, halted=1, step=0x01. Block stays idle with run=1. A step_req pulse clears halted and starts a cycle.
5. run=1, drop run during phase 1 -> the cycle completes through phase 3, then IDLE with step advanced by one. Raising run again resumes at phase 0.
6. Assert reset during phase 2 at step 0x10 -> on the next sys_clk all outputs are 0, step=0x01, halted=0. Free-run restarts only after reset is deasserted.

Source files
------------

// File: rtl/stepper_clock_gen.sv
// Four-phase computer clock generator with integrated one-hot instruction stepper
// and run / single-step / halt-at-instruction-end control.
module stepper_clock_gen #(
    parameter int QTR_CYCLES = 1,
    parameter int STEPS      = 7
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             run,
    input  logic             single,
    input  logic             step_req,
    input  logic             halt,
    output logic             clk,
    output logic             clk_d,
    output logic             clk_e,
    output logic             clk_s,
    output logic [STEPS-1:0] step,
    output logic             cycle_end,
    output logic             instr_end,
    output logic             halted
);

    localparam int QW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
    localparam int IW = $clog2(STEPS);
    localparam logic [QW-1:0] QTR_LAST  = QW'(QTR_CYCLES - 1);
    localparam logic [IW-1:0] STEP_LAST = IW'(STEPS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            halted_q, halted_d;

    logic running, qtr_wrap, cyc_end, ins_end, start;

    assign running  = (state_q == RUN);
    assign qtr_wrap = (qcnt_q == QTR_LAST);
    assign cyc_end  = running && (phase_q == 2'd3) && qtr_wrap;
    assign ins_end  = cyc_end && (idx_q == STEP_LAST);
    // A step_req in free-run overrides a pending halted flag, acting as a restart.
    assign start    = single ? step_req : (run && (!halted_q || step_req));

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= 2'd0;
            qcnt_q   <= '0;
            idx_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            qcnt_q   <= qcnt_d;
            idx_q    <= idx_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        qcnt_d   = qcnt_q;
        idx_d    = idx_q;
        halted_d = halted_q;
        case (state_q)
            IDLE: begin
                if (step_req) halted_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    phase_d = 2'd0;
                    qcnt_d  = '0;
                end
            end
            RUN: begin
                if (qtr_wrap) begin
                    qcnt_d  = '0;
                    phase_d = phase_q + 2'd1;
                end else begin
                    qcnt_d = qcnt_q + 1'b1;
                end
                // Mode inputs are only acted on at the cycle boundary so no cycle is truncated.
                if (cyc_end) begin
                    idx_d = (idx_q == STEP_LAST) ? '0 : idx_q + 1'b1;
                    if (ins_end && halt) begin
                        state_d  = IDLE;
                        halted_d = 1'b1;
                    end else if (single || !run) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clk       = running && !phase_q[1];
    assign clk_d     = running && (phase_q[1] ^ phase_q[0]);
    assign clk_e     = clk | clk_d;
    assign clk_s     = clk & clk_d;
    assign step      = STEPS'(1) << idx_q;
    assign cycle_end = cyc_end;
    assign instr_end = ins_end;
    assign halted    = halted_q;

endmodule

// File: tb/tb_stepper_clock_gen.sv
// Scoreboard bench: two instances (QTR_CYCLES=1 and 3) share stimulus and are compared
// every sys_clk against a cycle-position reference model.
module tb_stepper_clock_gen;

    localparam int STEPS = 7;

    logic sys_clk = 1'b0;
    logic reset, run, single, step_req, halt;

    logic             clk_w [2];
    logic             clkd_w[2];
    logic             clke_w[2];
    logic             clks_w[2];
    logic [STEPS-1:0] step_w[2];
    logic             ce_w  [2];
    logic             ie_w  [2];
    logic             hlt_w [2];

    always #5 sys_clk = ~sys_clk;

    stepper_clock_gen #(.QTR_CYCLES(1), .STEPS(STEPS)) u_q1 (
        .sys_clk(sys_clk), .reset(reset), .run(run), .single(single),
        .step_req(step_req), .halt(halt),
        .clk(clk_w[0]), .clk_d(clkd_w[0]), .clk_e(clke_w[0]), .clk_s(clks_w[0]),
        .step(step_w[0]), .cycle_end(ce_w[0]), .instr_end(ie_w[0]), .halted(hlt_w[0])
    );

    stepper_clock_gen #(.QTR_CYCLES(3), .STEPS(STEPS)) u_q3 (
        .sys_clk(sys_clk), .reset(reset), .run(run), .single(single),
        .step_req(step_req), .halt(halt),
        .clk(clk_w[1]), .clk_d(clkd_w[1]), .clk_e(clke_w[1]), .clk_s(clks_w[1]),
        .step(step_w[1]), .cycle_end(ce_w[1]), .instr_end(ie_w[1]), .halted(hlt_w[1])
    );

    int checks = 0;
    int errors = 0;

    logic [13:0] sb0[$];
    logic [13:0] sb1[$];

    // Model: running flag, position within the computer cycle (0..4Q-1), step index, halted.
    int m_run[2], m_pos[2], m_stp[2], m_hlt[2];

    function automatic int qof(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic model_step(int k);
        int q;
        int last;
        q = qof(k);
        if (reset) begin
            m_run[k] = 0; m_pos[k] = 0; m_stp[k] = 0; m_hlt[k] = 0;
        end else if (m_run[k] == 0) begin
            if (single) m_run[k] = step_req ? 1 : 0;
            else        m_run[k] = (run && (!m_hlt[k] || step_req)) ? 1 : 0;
            if (step_req) m_hlt[k] = 0;
            m_pos[k] = 0;
        end else if (m_pos[k] == 4*q - 1) begin
            last     = (m_stp[k] == STEPS - 1) ? 1 : 0;
            m_stp[k] = (m_stp[k] + 1) % STEPS;
            m_pos[k] = 0;
            if (last && halt) begin
                m_run[k] = 0; m_hlt[k] = 1;
            end else if (single || !run) begin
                m_run[k] = 0;
            end
        end else begin
            m_pos[k] = m_pos[k] + 1;
        end
    endtask

    function automatic logic [13:0] model_out(int k);
        int ph;
        logic c, cd, e, s, ce, ie;
        logic [STEPS-1:0] st;
        ph = m_pos[k] / qof(k);
        c  = m_run[k] && (ph == 0 || ph == 1);
        cd = m_run[k] && (ph == 1 || ph == 2);
        e  = m_run[k] && (ph != 3);
        s  = m_run[k] && (ph == 1);
        ce = m_run[k] && (m_pos[k] == 4*qof(k) - 1);
        ie = ce && (m_stp[k] == STEPS - 1);
        st = '0;
        st[m_stp[k]] = 1'b1;
        return {c, cd, e, s, ce, ie, (m_hlt[k] != 0), st};
    endfunction

    function automatic logic [13:0] dut_vec(int k);
        return {clk_w[k], clkd_w[k], clke_w[k], clks_w[k], ce_w[k], ie_w[k], hlt_w[k], step_w[k]};
    endfunction

    task automatic chk(string name, logic [13:0] act, logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        sb0.push_back(model_out(0));
        sb1.push_back(model_out(1));
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic pulse_step();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
    endtask

    // Monitor: compares each DUT against the expected response queued for that edge.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (sb0.size() > 0) chk("sb_q1", dut_vec(0), sb0.pop_front());
            if (sb1.size() > 0) chk("sb_q3", dut_vec(1), sb1.pop_front());
        end
    end

    initial begin
        reset = 1'b1; run = 1'b1; single = 1'b0; step_req = 1'b0; halt = 1'b0;
        @(negedge sys_clk);
        repeat (3) tick();
        chk("reset_state_q1", dut_vec(0), 14'h0001);
        chk("reset_state_q3", dut_vec(1), 14'h0001);

        // Free-run after reset release: phase pattern, stepper walk, instr_end period.
        reset = 1'b0;
        repeat (60) tick();

        // Drop run during phase 1: cycle completes, then idle; raise again resumes.
        for (int n = 0; n < 50 && !(m_run[1] && m_pos[1] / 3 == 1); n++) tick();
        run = 1'b0;
        for (int n = 0; n < 50 && m_run[1]; n++) tick();
        chk("run_drop_idle", {13'd0, clk_w[1]}, 14'd0);
        repeat (5) tick();
        run = 1'b1;
        repeat (20) tick();

        // Reset mid-cycle at step 0x10, phase 2.
        for (int n = 0; n < 200 && !(m_run[1] && m_stp[1] == 4 && m_pos[1] / 3 == 2); n++) tick();
        chk("reach_step10", {7'd0, step_w[1]}, 14'h0010);
        reset = 1'b1;
        tick();
        chk("midreset_q3", dut_vec(1), 14'h0001);
        chk("midreset_q1", dut_vec(0), 14'h0001);
        repeat (3) tick();
        chk("held_reset", dut_vec(1), 14'h0001);
        reset = 1'b0;
        repeat (10) tick();

        // Single-step from step 0x04; a step_req issued mid-cycle is ignored.
        single = 1'b1; run = 1'b0;
        for (int n = 0; n < 50 && m_run[1]; n++) tick();
        for (int n = 0; n < 20 && m_stp[1] != 2; n++) begin
            pulse_step();
            for (int j = 0; j < 40 && m_run[1]; j++) tick();
        end
        chk("single_at_04", dut_vec(1), 14'h0004);
        pulse_step();
        tick(); tick();
        pulse_step();
        for (int n = 0; n < 40 && m_run[1]; n++) tick();
        repeat (5) tick();
        chk("single_after", dut_vec(1), 14'h0008);

        // Halt raised during step 0x04 stops after the instruction; run=1 does not restart.
        single = 1'b0; run = 1'b1;
        for (int n = 0; n < 100 && !(m_run[1] && m_stp[1] == 2); n++) tick();
        halt = 1'b1;
        for (int n = 0; n < 200 && !m_hlt[1]; n++) tick();
        halt = 1'b0;
        repeat (20) tick();
        chk("halted_idle", dut_vec(1), 14'h0081);
        pulse_step();
        chk("halt_cleared", {13'd0, hlt_w[1]}, 14'd0);
        chk("restart_clk", {13'd0, clk_w[1]}, 14'd1);
        repeat (30) tick();

        // Randomized mix of all controls.
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 149) == 0);
            run      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) single = ~single;
            step_req = ($urandom_range(0, 9) == 0);
            halt     = ($urandom_range(0, 4) == 0);
            tick();
        end
        reset = 1'b0; step_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
